// File: rtl/apb_mem_slave_p.sv
// APB4 completer in front of a byte-lane-writable register-file memory.
// Adds configurable widths/depth, programmable wait states and PSLVERR decode.
module apb_mem_slave_p #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic                PWRITE,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic                state_dbg
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BL     = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W  = ADDR_W + 12;

  // Handshake: a transfer is accepted on an edge with PSEL=1, PENABLE=0
  // (setup) and completes on the edge where PSEL=1, PENABLE=1 and PREADY=1.
  // PREADY/PSLVERR are decoded from registered state only.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                load;
  logic                dec;
  logic                complete;
  logic [3:0]          wait_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic                misaligned;
  logic                out_of_range;
  logic                err_d;
  logic [IDX_W-1:0]    idx_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign word_idx     = PADDR >> BL;
  assign misaligned   = (PADDR & ADDR_W'(STRB_W - 1)) != '0;
  // Full upper address bits take part in the range check; no aliasing.
  assign out_of_range = CMP_W'(word_idx) >= CMP_W'(DEPTH);
  assign err_d        = misaligned | out_of_range;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    dec      = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (!PENABLE) begin
          // Setup seen mid-access: drop the old transfer and restart.
          load = 1'b1;
        end else if (wait_cnt != 4'd0) begin
          dec = 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      PRDATA   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx_q    <= word_idx[IDX_W-1:0];
        write_q  <= PWRITE;
        wdata_q  <= PWDATA;
        strb_q   <= PSTRB;
        err_q    <= err_d;
        wait_cnt <= 4'(WAIT_STATES);
        if (!PWRITE) begin
          PRDATA <= err_d ? '0 : mem[word_idx[IDX_W-1:0]];
        end
      end else if (dec) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && write_q && !err_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign PREADY    = (state_q == ACCESS) && (wait_cnt == 4'd0);
  assign PSLVERR   = PREADY && err_q;
  assign state_dbg = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p: three instances (32b/WS0, 32b/WS3, 64b depth-4/WS1)
// checked against an array-based memory model with random and directed traffic.
module tb_apb_mem_slave_p;

  logic        clk = 1'b0;
  logic        preset;
  logic        psel_a, psel_b, psel_c;
  logic        penable, pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [31:0] prdata_a, prdata_b;
  logic [63:0] prdata_c;
  logic        pready_a, pready_b, pready_c;
  logic        pslverr_a, pslverr_b, pslverr_c;
  logic        dbg_a, dbg_b, dbg_c;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem_m [3][32];

  always #5 clk = ~clk;

  apb_mem_slave_p #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .WAIT_STATES(0)) dut_a (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_a), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PRDATA(prdata_a),
    .PREADY(pready_a), .PSLVERR(pslverr_a), .state_dbg(dbg_a));

  apb_mem_slave_p #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .WAIT_STATES(3)) dut_b (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_b), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PRDATA(prdata_b),
    .PREADY(pready_b), .PSLVERR(pslverr_b), .state_dbg(dbg_b));

  apb_mem_slave_p #(.ADDR_W(32), .DATA_W(64), .DEPTH(4), .WAIT_STATES(1)) dut_c (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_c), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_c),
    .PREADY(pready_c), .PSLVERR(pslverr_c), .state_dbg(dbg_c));

  // ---------------- reference model ----------------
  function automatic int nbytes(int w);
    return (w == 2) ? 8 : 4;
  endfunction

  function automatic int depth(int w);
    return (w == 2) ? 4 : 32;
  endfunction

  function automatic int wait_states(int w);
    return (w == 0) ? 0 : (w == 1) ? 3 : 1;
  endfunction

  function automatic bit m_err(int w, logic [31:0] a);
    return ((a % 32'(nbytes(w))) != 0) || ((a / 32'(nbytes(w))) >= 32'(depth(w)));
  endfunction

  function automatic logic [63:0] m_read(int w, logic [31:0] a);
    if (m_err(w, a)) return 64'd0;
    return mem_m[w][a / 32'(nbytes(w))];
  endfunction

  task automatic m_write(int w, logic [31:0] a, logic [63:0] d, logic [7:0] s);
    if (!m_err(w, a)) begin
      for (int i = 0; i < nbytes(w); i++) begin
        if (s[i]) mem_m[w][a / 32'(nbytes(w))][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic m_clear();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 32; i++) mem_m[w][i] = 64'd0;
  endtask

  // ---------------- DUT output muxing ----------------
  function automatic logic [63:0] out_rdata(int w);
    case (w)
      0:       return {32'd0, prdata_a};
      1:       return {32'd0, prdata_b};
      default: return prdata_c;
    endcase
  endfunction

  function automatic logic out_ready(int w);
    case (w)
      0:       return pready_a;
      1:       return pready_b;
      default: return pready_c;
    endcase
  endfunction

  function automatic logic out_err(int w);
    case (w)
      0:       return pslverr_a;
      1:       return pslverr_b;
      default: return pslverr_c;
    endcase
  endfunction

  function automatic logic out_dbg(int w);
    case (w)
      0:       return dbg_a;
      1:       return dbg_b;
      default: return dbg_c;
    endcase
  endfunction

  task automatic set_psel(int w, logic v);
    psel_a = (w == 0) && v;
    psel_b = (w == 1) && v;
    psel_c = (w == 2) && v;
  endtask

  // ---------------- driver ----------------
  // Returns data/err seen with PREADY, number of access cycles, and how many
  // wait cycles showed PSLVERR while PREADY was low.
  task automatic xfer(input int w, input bit wr, input logic [31:0] a,
                      input logic [63:0] d, input logic [7:0] s,
                      output logic [63:0] rd, output logic er,
                      output int acc, output int early, output bit tmo);
    @(posedge clk); #1;
    set_psel(w, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 0; early = 0; tmo = 1'b1; rd = '0; er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc++;
      if (out_ready(w)) begin
        rd = out_rdata(w); er = out_err(w); tmo = 1'b0;
        break;
      end
      if (out_err(w)) early++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_psel(w, 1'b0);
    penable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset = 1'b1; set_psel(0, 1'b0); penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    m_clear();
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      total++; if (out_ready(w) !== 1'b0) begin bad++; $display("FAIL reset_pready w%0d: got %b want 0", w, out_ready(w)); end
      total++; if (out_err(w) !== 1'b0) begin bad++; $display("FAIL reset_pslverr w%0d: got %b want 0", w, out_err(w)); end
      total++; if (out_rdata(w) !== 64'd0) begin bad++; $display("FAIL reset_prdata w%0d: got %h want 0", w, out_rdata(w)); end
      total++; if (out_dbg(w) !== 1'b0) begin bad++; $display("FAIL reset_state w%0d: got %b want 0", w, out_dbg(w)); end
    end
    @(posedge clk); #1;
    preset = 1'b0;
  endtask

  task automatic test_defaults();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(0, 1, 32'h10, 64'hDEADBEEF, 8'hF, rd, er, acc, early, tmo);
    m_write(0, 32'h10, 64'hDEADBEEF, 8'hF);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL def_wr_err: got %b want 0", er); end
    total++; if (acc !== 1) begin bad++; $display("FAIL def_wr_cycles: got %0d access cycles want 1", acc); end
    xfer(0, 0, 32'h10, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'hDEADBEEF) begin bad++; $display("FAIL def_rd_data: got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL def_rd_err: got %b want 0", er); end
    total++; if (acc !== 1) begin bad++; $display("FAIL def_rd_cycles: got %0d want 1", acc); end
    // A write must leave the last read data on PRDATA.
    xfer(0, 1, 32'h14, 64'h0, 8'hF, rd, er, acc, early, tmo);
    m_write(0, 32'h14, 64'h0, 8'hF);
    total++; if (out_rdata(0) !== 64'hDEADBEEF) begin bad++; $display("FAIL def_prdata_hold: got %h want deadbeef", out_rdata(0)); end
  endtask

  task automatic test_partial_write();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(0, 1, 32'h08, 64'h11223344, 8'hF, rd, er, acc, early, tmo);
    m_write(0, 32'h08, 64'h11223344, 8'hF);
    xfer(0, 1, 32'h08, 64'hAABBCCDD, 8'h5, rd, er, acc, early, tmo);
    m_write(0, 32'h08, 64'hAABBCCDD, 8'h5);
    xfer(0, 0, 32'h08, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'h11BB33DD) begin bad++; $display("FAIL partial_rd: got %h want 11bb33dd", rd); end
    // Zero strobe: OKAY, no change.
    xfer(0, 1, 32'h08, 64'hFFFFFFFF, 8'h0, rd, er, acc, early, tmo);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL strb0_err: got %b want 0", er); end
    xfer(0, 0, 32'h08, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'h11BB33DD) begin bad++; $display("FAIL strb0_rd: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(0, 1, 32'h80, 64'h12345678, 8'hF, rd, er, acc, early, tmo);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_wr80: got %b want 1", er); end
    xfer(0, 0, 32'h00, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL err_mem0: got %h want 0", rd); end
    xfer(0, 0, 32'h7C, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL err_rd7c: got %b want 0", er); end
    xfer(0, 0, 32'h10, 64'd0, 8'h0, rd, er, acc, early, tmo);
    xfer(0, 0, 32'h02, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_rd02: got %b want 1", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL err_rd02_data: got %h want 0", rd); end
    xfer(0, 0, 32'h0001_0000, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_highbits: got %b want 1", er); end
  endtask

  task automatic test_wait_states();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(1, 1, 32'h20, 64'hCAFEF00D, 8'hF, rd, er, acc, early, tmo);
    m_write(1, 32'h20, 64'hCAFEF00D, 8'hF);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL ws3_timeout: got %b want 0", tmo); end
    total++; if (acc !== 4) begin bad++; $display("FAIL ws3_cycles: got %0d want 4", acc); end
    total++; if (early !== 0) begin bad++; $display("FAIL ws3_early_err: got %0d want 0", early); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL ws3_err: got %b want 0", er); end
    xfer(1, 0, 32'h20, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'hCAFEF00D) begin bad++; $display("FAIL ws3_rd: got %h want cafef00d", rd); end
    xfer(1, 0, 32'h21, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (early !== 0 || er !== 1'b1) begin bad++; $display("FAIL ws3_err_timing: got early=%0d err=%b want 0/1", early, er); end
  endtask

  task automatic test_wide();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(2, 1, 32'h18, 64'h0123456789ABCDEF, 8'hFF, rd, er, acc, early, tmo);
    m_write(2, 32'h18, 64'h0123456789ABCDEF, 8'hFF);
    total++; if (acc !== 2) begin bad++; $display("FAIL wide_cycles: got %0d want 2", acc); end
    xfer(2, 0, 32'h18, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL wide_rd: got %h want 0123456789abcdef", rd); end
    xfer(2, 1, 32'h20, 64'h1, 8'hFF, rd, er, acc, early, tmo);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL wide_err20: got %b want 1", er); end
    xfer(2, 1, 32'h1C, 64'h1, 8'hFF, rd, er, acc, early, tmo);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL wide_err1c: got %b want 1", er); end
    xfer(2, 0, 32'h18, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL wide_rd2: got %h want 0123456789abcdef", rd); end
  endtask

  task automatic test_psel_abort();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(1, 1, 32'h0C, 64'h0BADF00D, 8'hF, rd, er, acc, early, tmo);
    m_write(1, 32'h0C, 64'h0BADF00D, 8'hF);
    @(posedge clk); #1;
    set_psel(1, 1'b1); penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 64'h99999999; pstrb = 8'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1;
    set_psel(1, 1'b0); penable = 0;
    @(posedge clk); #1;
    total++; if (dbg_b !== 1'b0) begin bad++; $display("FAIL abort_state: got %b want 0", dbg_b); end
    xfer(1, 0, 32'h0C, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== m_read(1, 32'h0C)) begin bad++; $display("FAIL abort_nowrite: got %h want %h", rd, m_read(1, 32'h0C)); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    xfer(1, 1, 32'h08, 64'h77, 8'hF, rd, er, acc, early, tmo);
    xfer(1, 0, 32'h08, 64'd0, 8'h0, rd, er, acc, early, tmo);
    @(posedge clk); #1;
    set_psel(1, 1'b1); penable = 0; pwrite = 1; paddr = 32'h04; pwdata = 64'h5A5A5A5A; pstrb = 8'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #2 preset = 1'b1;
    #1;
    m_clear();
    total++; if (pready_b !== 1'b0) begin bad++; $display("FAIL rst_abort_pready: got %b want 0", pready_b); end
    total++; if (prdata_b !== 32'd0) begin bad++; $display("FAIL rst_abort_prdata: got %h want 0", prdata_b); end
    total++; if (dbg_b !== 1'b0) begin bad++; $display("FAIL rst_abort_state: got %b want 0", dbg_b); end
    @(posedge clk); #1;
    set_psel(1, 1'b0); penable = 0;
    preset = 1'b0;
    xfer(1, 0, 32'h04, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL rst_abort_rd04: got %h want 0", rd); end
    xfer(1, 0, 32'h08, 64'd0, 8'h0, rd, er, acc, early, tmo);
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL rst_abort_rd08: got %h want 0", rd); end
  endtask

  task automatic test_random_traffic();
    logic [63:0] rd; logic er; int acc, early; bit tmo;
    int w; bit wr; logic [31:0] a; logic [63:0] d; logic [7:0] s; logic [63:0] exp_d;
    for (int n = 0; n < 80; n++) begin
      w  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, depth(w) + 2) * nbytes(w));
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, nbytes(w) - 1));
      d  = {$urandom, $urandom};
      s  = 8'($urandom) & ((w == 2) ? 8'hFF : 8'h0F);
      exp_d = m_read(w, a);
      xfer(w, wr, a, d, s, rd, er, acc, early, tmo);
      total++; if (tmo !== 1'b0 || acc !== wait_states(w) + 1) begin bad++; $display("FAIL rnd_cycles n%0d: got %0d want %0d", n, acc, wait_states(w) + 1); end
      total++; if (er !== m_err(w, a) || early !== 0) begin bad++; $display("FAIL rnd_err n%0d a=%h: got %b want %b", n, a, er, m_err(w, a)); end
      if (wr) begin
        m_write(w, a, d, s);
      end else begin
        total++; if (rd !== exp_d) begin bad++; $display("FAIL rnd_rd n%0d w%0d a=%h: got %h want %h", n, w, a, rd, exp_d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_partial_write();
    test_errors();
    test_wait_states();
    test_wide();
    test_psel_abort();
    test_reset_abort();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
